// File: rtl/shifter_pipe_pkg.sv
// Shared definitions for the pipelined barrel shifter: mode encodings,
// the per-stage bundle layout and the stage distance helper.
package shifter_pkg;

  localparam logic [1:0] MODE_SLL = 2'b00;
  localparam logic [1:0] MODE_SRA = 2'b01;
  localparam logic [1:0] MODE_SRL = 2'b10;
  localparam logic [1:0] MODE_ROR = 2'b11;

  localparam int DEF_WIDTH = 16;
  localparam int DEF_SHW   = $clog2(DEF_WIDTH);
  localparam int DEF_TAG_W = 4;

  // Bundle carried from one stage register to the next, default geometry.
  // Stages declare the same layout sized by their own parameters.
  typedef struct packed {
    logic                 valid;
    logic [DEF_WIDTH-1:0] data;
    logic [DEF_SHW-1:0]   amt;
    logic [1:0]           mode;
    logic                 sign;
    logic [DEF_TAG_W-1:0] tag;
  } stage_bundle_t;

  // Shift distance handled by stage k.
  function automatic int stage_dist(input int k);
    return 1 << k;
  endfunction

endpackage

// File: rtl/shifter_pipe_if.sv
// Operation/result bus of the shifter: input handshake with operand,
// amount, mode and tag; output handshake with result, tag and zero flag.
interface shifter_pipe_if #(
  parameter int WIDTH = 16,
  parameter int SHW   = $clog2(WIDTH),
  parameter int TAG_W = 4
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic [SHW-1:0]   in_amt;
  logic [1:0]       in_mode;
  logic [TAG_W-1:0] in_tag;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic [TAG_W-1:0] out_tag;
  logic             out_zero;

  modport master (
    output in_valid, in_data, in_amt, in_mode, in_tag, out_ready,
    input  in_ready, out_valid, out_data, out_tag, out_zero
  );

  modport slave (
    input  in_valid, in_data, in_amt, in_mode, in_tag, out_ready,
    output in_ready, out_valid, out_data, out_tag, out_zero
  );
endinterface

// File: rtl/shifter_pipe_stage.sv
// One shifter level: conditionally shifts by DIST (selected by amt bit
// log2(DIST)) in one of four modes, then registers the whole bundle when
// the pipeline advances.
module shifter_stage
  import shifter_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int SHW   = 4,
  parameter int TAG_W = 4,
  parameter int DIST  = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             adv,
  input  logic             valid_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic [SHW-1:0]   amt_i,
  input  logic [1:0]       mode_i,
  input  logic             sign_i,
  input  logic [TAG_W-1:0] tag_i,
  output logic             valid_o,
  output logic [WIDTH-1:0] data_o,
  output logic [SHW-1:0]   amt_o,
  output logic [1:0]       mode_o,
  output logic             sign_o,
  output logic [TAG_W-1:0] tag_o
);

  localparam int K = $clog2(DIST);

  typedef struct packed {
    logic             valid;
    logic [WIDTH-1:0] data;
    logic [SHW-1:0]   amt;
    logic [1:0]       mode;
    logic             sign;
    logic [TAG_W-1:0] tag;
  } bundle_t;

  bundle_t          bundle_d;
  bundle_t          bundle_q;
  logic [WIDTH-1:0] shifted;

  // Shift by DIST in the selected mode; SRA fills with the original sign.
  always_comb begin
    shifted = data_i;
    if (amt_i[K]) begin
      case (mode_i)
        MODE_SLL: shifted = {data_i[WIDTH-DIST-1:0], {DIST{1'b0}}};
        MODE_SRA: shifted = {{DIST{sign_i}}, data_i[WIDTH-1:DIST]};
        MODE_SRL: shifted = {{DIST{1'b0}}, data_i[WIDTH-1:DIST]};
        MODE_ROR: shifted = {data_i[DIST-1:0], data_i[WIDTH-1:DIST]};
      endcase
    end
  end

  // Load the bundle from the predecessor on advance, otherwise hold.
  always_comb begin
    bundle_d = bundle_q;
    if (adv) begin
      bundle_d.valid = valid_i;
      bundle_d.data  = shifted;
      bundle_d.amt   = amt_i;
      bundle_d.mode  = mode_i;
      bundle_d.sign  = sign_i;
      bundle_d.tag   = tag_i;
    end
  end

  // Stage register; reset discards whatever is in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) bundle_q <= '0;
    else        bundle_q <= bundle_d;
  end

  assign valid_o = bundle_q.valid;
  assign data_o  = bundle_q.data;
  assign amt_o   = bundle_q.amt;
  assign mode_o  = bundle_q.mode;
  assign sign_o  = bundle_q.sign;
  assign tag_o   = bundle_q.tag;

endmodule

// File: rtl/shifter_pipe.sv
// Pipelined barrel shifter (SLL/SRA/SRL/ROR) with one register stage per
// shift level and valid/ready flow control. The whole pipe advances as a
// unit whenever the output slot is empty or being taken.
module shifter_pipe
  import shifter_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int SHW   = $clog2(WIDTH),
  parameter int TAG_W = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  shifter_pipe_if.slave  bus
);

  logic                        adv;
  logic [SHW:0]                valid_c;
  logic [SHW:0][WIDTH-1:0]     data_c;
  logic [SHW:0][SHW-1:0]       amt_c;
  logic [SHW:0][1:0]           mode_c;
  logic [SHW:0]                sign_c;
  logic [SHW:0][TAG_W-1:0]     tag_c;
  logic                        unused_tail;

  assign valid_c[0] = bus.in_valid;
  assign data_c[0]  = bus.in_data;
  assign amt_c[0]   = bus.in_amt;
  assign mode_c[0]  = bus.in_mode;
  assign sign_c[0]  = bus.in_data[WIDTH-1];
  assign tag_c[0]   = bus.in_tag;

  genvar gi;
  generate
    for (gi = 0; gi < SHW; gi++) begin : g_stage
      shifter_stage #(
        .WIDTH (WIDTH),
        .SHW   (SHW),
        .TAG_W (TAG_W),
        .DIST  (stage_dist(gi))
      ) u_stage (
        .clk     (clk),
        .rst_n   (rst_n),
        .adv     (adv),
        .valid_i (valid_c[gi]),
        .data_i  (data_c[gi]),
        .amt_i   (amt_c[gi]),
        .mode_i  (mode_c[gi]),
        .sign_i  (sign_c[gi]),
        .tag_i   (tag_c[gi]),
        .valid_o (valid_c[gi+1]),
        .data_o  (data_c[gi+1]),
        .amt_o   (amt_c[gi+1]),
        .mode_o  (mode_c[gi+1]),
        .sign_o  (sign_c[gi+1]),
        .tag_o   (tag_c[gi+1])
      );
    end
  endgenerate

  // Advance whenever the output slot is empty or is being consumed.
  assign adv          = ~valid_c[SHW] | bus.out_ready;
  assign bus.in_ready = adv;

  assign bus.out_valid = valid_c[SHW];
  assign bus.out_data  = data_c[SHW];
  assign bus.out_tag   = tag_c[SHW];
  assign bus.out_zero  = (data_c[SHW] == '0);

  // Amount, mode and sign are no longer needed after the last level.
  assign unused_tail = ^{amt_c[SHW], mode_c[SHW], sign_c[SHW]};

endmodule

// File: tb/tb_shifter_pipe.sv
// Scoreboard bench for shifter_pipe (WIDTH=16, TAG_W=4): directed vectors
// push expected results at accept time; a monitor pops and compares on
// every output handshake and also checks hold stability and latency.
module tb_shifter_pipe;
  import shifter_pkg::*;

  localparam int WIDTH = 16;
  localparam int SHW   = 4;
  localparam int TAG_W = 4;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  shifter_pipe_if #(.WIDTH(WIDTH), .SHW(SHW), .TAG_W(TAG_W)) bus ();

  shifter_pipe #(.WIDTH(WIDTH), .SHW(SHW), .TAG_W(TAG_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    logic [15:0] data;
    logic [3:0]  tag;
    int          acc;
    bit          lat_chk;
  } exp_t;

  typedef struct {
    logic [15:0] d;
    logic [3:0]  a;
    logic [1:0]  m;
    logic [15:0] e;
  } vec_t;

  exp_t sbq[$];
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;
  int   wcnt;
  bit   lat_chk_en = 1'b0;
  bit   rand_rdy   = 1'b0;

  bit          head_seen = 1'b0;
  bit          prev_hold = 1'b0;
  logic [15:0] prev_data;
  logic [3:0]  prev_tag;

  logic [15:0] sra_exp [16] = '{
    16'h8001, 16'hC000, 16'hE000, 16'hF000, 16'hF800, 16'hFC00, 16'hFE00, 16'hFF00,
    16'hFF80, 16'hFFC0, 16'hFFE0, 16'hFFF0, 16'hFFF8, 16'hFFFC, 16'hFFFE, 16'hFFFF
  };

  vec_t bub [9] = '{
    '{16'h0F0F, 4'd2,  MODE_SLL, 16'h3C3C},
    '{16'hF0F0, 4'd8,  MODE_SRA, 16'hFFF0},
    '{16'hF0F0, 4'd8,  MODE_SRL, 16'h00F0},
    '{16'hABCD, 4'd8,  MODE_ROR, 16'hCDAB},
    '{16'h8001, 4'd15, MODE_ROR, 16'h0003},
    '{16'h1234, 4'd12, MODE_SLL, 16'h4000},
    '{16'h4000, 4'd14, MODE_SRA, 16'h0001},
    '{16'hFFFF, 4'd15, MODE_SRL, 16'h0001},
    '{16'h0003, 4'd2,  MODE_ROR, 16'hC000}
  };

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // Monitor: compare on handshake, check hold stability and latency.
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      head_seen = 1'b0;
      prev_hold = 1'b0;
    end else begin
      if (prev_hold) begin
        check("hold_valid", {31'd0, bus.out_valid}, 32'd1);
        check("hold_data", {16'd0, bus.out_data}, {16'd0, prev_data});
        check("hold_tag", {28'd0, bus.out_tag}, {28'd0, prev_tag});
      end
      if (bus.out_valid && !bus.out_ready)
        check("hold_in_ready", {31'd0, bus.in_ready}, 32'd0);
      if (bus.out_valid) begin
        if (sbq.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_result actual data=%h tag=%0d required=no result",
                   bus.out_data, bus.out_tag);
        end else begin
          if (!head_seen) begin
            head_seen = 1'b1;
            if (sbq[0].lat_chk)
              check("latency", cyc - sbq[0].acc, SHW);
          end
          if (bus.out_ready) begin
            e = sbq.pop_front();
            check("data", {16'd0, bus.out_data}, {16'd0, e.data});
            check("tag", {28'd0, bus.out_tag}, {28'd0, e.tag});
            check("zero", {31'd0, bus.out_zero}, {31'd0, (e.data == 16'h0000)});
            $display("txn tag=%0d data=%h zero=%0b", bus.out_tag, bus.out_data, bus.out_zero);
            head_seen = 1'b0;
          end
        end
      end
      prev_hold = bus.out_valid && !bus.out_ready;
      prev_data = bus.out_data;
      prev_tag  = bus.out_tag;
    end
  end

  // Random consumer readiness for the bubble phase.
  always @(posedge clk) begin
    if (rand_rdy) begin
      #1;
      bus.out_ready = ($urandom_range(0, 1) == 1);
    end
  end

  task automatic issue(input logic [15:0] d, input logic [3:0] a, input logic [1:0] m,
                       input logic [3:0] t, input logic [15:0] ex);
    exp_t e;
    bit   done = 1'b0;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    bus.in_amt   = a;
    bus.in_mode  = m;
    bus.in_tag   = t;
    for (int i = 0; i < 64 && !done; i++) begin
      @(negedge clk);
      if (bus.in_ready) begin
        e.data    = ex;
        e.tag     = t;
        e.acc     = cyc;
        e.lat_chk = lat_chk_en;
        sbq.push_back(e);
        done = 1'b1;
      end else begin
        @(posedge clk);
        #1;
      end
    end
    if (!done) begin
      total++;
      bad++;
      $display("FAIL accept_timeout tag=%0d actual in_ready=0 required=1", t);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
    end
  endtask

  task automatic drain();
    for (int i = 0; i < 200 && sbq.size() != 0; i++) @(negedge clk);
    @(negedge clk);
    if (sbq.size() != 0) begin
      total++;
      bad++;
      $display("FAIL drain_timeout actual pending=%0d required=0", sbq.size());
      sbq.delete();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.in_amt    = '0;
    bus.in_mode   = '0;
    bus.in_tag    = '0;
    bus.out_ready = 1'b0;

    // Reset state
    #12;
    check("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
    check("rst_out_data", {16'd0, bus.out_data}, 32'd0);
    check("rst_out_tag", {28'd0, bus.out_tag}, 32'd0);
    check("rst_out_zero", {31'd0, bus.out_zero}, 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("rel_in_ready", {31'd0, bus.in_ready}, 32'd1);
    bus.out_ready = 1'b1;

    // Modes with latency checks
    lat_chk_en = 1'b1;
    issue(16'h0001, 4'd15, MODE_SLL, 4'd1, 16'h8000);
    issue(16'h8000, 4'd4,  MODE_SRA, 4'd2, 16'hF800);
    issue(16'h8000, 4'd4,  MODE_SRL, 4'd3, 16'h0800);
    issue(16'h1234, 4'd4,  MODE_ROR, 4'd4, 16'h4123);
    idle(1);
    drain();

    // Identity and zero
    issue(16'hA5A5, 4'd0, MODE_SLL, 4'd5, 16'hA5A5);
    issue(16'hA5A5, 4'd0, MODE_SRA, 4'd6, 16'hA5A5);
    issue(16'hA5A5, 4'd0, MODE_SRL, 4'd7, 16'hA5A5);
    issue(16'hA5A5, 4'd0, MODE_ROR, 4'd8, 16'hA5A5);
    issue(16'h8000, 4'd1, MODE_SLL, 4'd9, 16'h0000);
    idle(1);
    drain();

    // Streaming
    for (int i = 0; i < 16; i++)
      issue(16'h8001, i[3:0], MODE_SRA, i[3:0], sra_exp[i]);
    idle(1);
    drain();
    lat_chk_en = 1'b0;

    // Backpressure
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    fork
      begin
        issue(16'hFFFF, 4'd8, MODE_SRL, 4'd10, 16'h00FF);
        issue(16'h0001, 4'd1, MODE_ROR, 4'd11, 16'h8000);
        issue(16'h00F0, 4'd4, MODE_SLL, 4'd12, 16'h0F00);
        issue(16'h7FFF, 4'd3, MODE_SRA, 4'd13, 16'h0FFF);
        issue(16'hF00F, 4'd4, MODE_ROR, 4'd14, 16'hFF00);
        idle(1);
      end
      begin
        wcnt = 0;
        while (!bus.out_valid && wcnt < 50) begin
          @(negedge clk);
          wcnt++;
        end
        repeat (6) @(posedge clk);
        #1;
        bus.out_ready = 1'b1;
      end
    join
    drain();

    // Bubbles with random consumer
    rand_rdy = 1'b1;
    for (int i = 0; i < 9; i++) begin
      issue(bub[i].d, bub[i].a, bub[i].m, i[3:0], bub[i].e);
      idle(1);
    end
    rand_rdy = 1'b0;
    @(posedge clk);
    #2;
    bus.out_ready = 1'b1;
    drain();

    // Reset with operations in flight
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    issue(16'h0001, 4'd1, MODE_SLL, 4'd1, 16'h0002);
    issue(16'h00F0, 4'd4, MODE_SRL, 4'd2, 16'h000F);
    issue(16'hF000, 4'd4, MODE_SRA, 4'd3, 16'hFF00);
    idle(1);
    repeat (4) @(posedge clk);
    #2;
    check("pre_rst_out_valid", {31'd0, bus.out_valid}, 32'd1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
    check("mid_rst_out_data", {16'd0, bus.out_data}, 32'd0);
    check("mid_rst_out_zero", {31'd0, bus.out_zero}, 32'd1);
    sbq.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("rel2_in_ready", {31'd0, bus.in_ready}, 32'd1);
    bus.out_ready = 1'b1;
    lat_chk_en = 1'b1;
    issue(16'h00FF, 4'd4, MODE_SRL, 4'd9, 16'h000F);
    idle(1);
    drain();
    repeat (6) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
